// File: rtl/pcie_cfg_pkg.sv
// Shared constants, FSM state type and byte-enable merge helper for the
// PCIe configuration target.
package pcie_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    localparam logic [9:0] DW_ID       = 10'd0;
    localparam logic [9:0] DW_CMD      = 10'd1;
    localparam logic [9:0] DW_CLASS    = 10'd2;
    localparam logic [9:0] DW_CACHE    = 10'd3;
    localparam logic [9:0] DW_BAR0_LO  = 10'd4;
    localparam logic [9:0] DW_BAR0_HI  = 10'd5;
    localparam logic [9:0] DW_BAR2_LO  = 10'd6;
    localparam logic [9:0] DW_BAR2_HI  = 10'd7;
    localparam logic [9:0] DW_CAP_PTR  = 10'd13;
    localparam logic [9:0] DW_INTR     = 10'd15;
    localparam logic [9:0] DW_MSI_CTL  = 10'd16;
    localparam logic [9:0] DW_MSI_ALO  = 10'd17;
    localparam logic [9:0] DW_MSI_AHI  = 10'd18;
    localparam logic [9:0] DW_MSI_DATA = 10'd19;
    localparam logic [9:0] DW_LIMIT    = 10'd20;

    localparam logic [7:0]  MSI_CAP_OFF = 8'h40;
    localparam logic [7:0]  MSI_CAP_ID  = 8'h05;
    localparam logic [15:0] CMD_RW_MASK = 16'h0546;
    localparam logic [15:0] STATUS_VAL  = 16'h0010;
    localparam logic [3:0]  BAR_ATTR    = 4'b1100;
    localparam logic [7:0]  INTR_PIN    = 8'h01;
    localparam logic [7:0]  MSI_CTL_64  = 8'h80;

    // Merge enabled bytes of wdata into cur; bits outside rw_mask keep cur.
    function automatic logic [31:0] apply_be(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be,
                                             input logic [31:0] rw_mask);
        logic [31:0] res;
        res = cur;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = (cur[i*8 +: 8] & ~rw_mask[i*8 +: 8]) |
                                (wdata[i*8 +: 8] & rw_mask[i*8 +: 8]);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pcie_cfg_bar64_reg.sv
// One 64-bit prefetchable memory BAR pair: bits below APERTURE read as zero,
// attribute nibble reads as 64-bit prefetchable.
module pcie_cfg_bar64_reg
    import pcie_cfg_pkg::*;
#(
    parameter int unsigned APERTURE = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enable,
    output logic [31:0] read_lo,
    output logic [31:0] read_hi,
    output logic [63:0] base
);

    localparam logic [63:0] RW_MASK = ~((64'd1 << APERTURE) - 64'd1);

    logic [63:0] bar;

    always_ff @(posedge clk) begin
        if (rst) begin
            bar <= '0;
        end else begin
            if (wr_lo) begin
                bar[31:0] <= apply_be(bar[31:0], write_data, byte_enable, RW_MASK[31:0]);
            end
            if (wr_hi) begin
                bar[63:32] <= apply_be(bar[63:32], write_data, byte_enable, RW_MASK[63:32]);
            end
        end
    end

    assign read_lo = bar[31:0] | {28'h0, BAR_ATTR};
    assign read_hi = bar[63:32];
    assign base    = bar;

endmodule

// File: rtl/pcie_cfg_mgmt_target.sv
// Configuration-management completer: Type-0 header plus MSI capability for
// function 0, with fixed request-to-done latency and registered exports.
module pcie_cfg_mgmt_target
    import pcie_cfg_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID     = 16'h1234,
    parameter logic [15:0] DEVICE_ID     = 16'h0001,
    parameter logic [31:0] CLASS_REV     = 32'h02000000,
    parameter int unsigned BAR0_APERTURE = 24,
    parameter int unsigned BAR2_APERTURE = 24,
    parameter int unsigned LATENCY       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  cfg_mgmt_addr,
    input  logic [7:0]  cfg_mgmt_function_number,
    input  logic        cfg_mgmt_write,
    input  logic [31:0] cfg_mgmt_write_data,
    input  logic [3:0]  cfg_mgmt_byte_enable,
    input  logic        cfg_mgmt_read,
    output logic [31:0] cfg_mgmt_read_data,
    output logic        cfg_mgmt_read_write_done,
    output logic        mem_space_enable,
    output logic        bus_master_enable,
    output logic [63:0] bar0_base,
    output logic [63:0] bar2_base,
    output logic        msi_enable,
    output logic [63:0] msi_addr,
    output logic [15:0] msi_data
);

    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic [9:0]  lat_addr;
    logic [7:0]  lat_func;
    logic [31:0] lat_data;
    logic [3:0]  lat_be;
    logic        lat_write;

    logic [31:0] cmd_dw, cache_dw, intr_dw, msictl_dw;
    logic [31:0] msi_alo, msi_ahi, msi_dat;
    logic [31:0] bar0_lo, bar0_hi, bar2_lo, bar2_hi;
    logic [63:0] bar0_val, bar2_val;

    logic        hit;
    logic        wr_en;
    logic [31:0] rd_val;

    assign hit   = (lat_func == 8'd0) && (lat_addr < DW_LIMIT);
    assign wr_en = (state == ST_DONE) && lat_write && hit;

    // A still-high done marks the cycle right after completion, where a held
    // request must not be taken as a new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                    <= ST_IDLE;
            cnt                      <= '0;
            lat_addr                 <= '0;
            lat_func                 <= '0;
            lat_data                 <= '0;
            lat_be                   <= '0;
            lat_write                <= 1'b0;
            cfg_mgmt_read_write_done <= 1'b0;
            cfg_mgmt_read_data       <= '0;
        end else begin
            cfg_mgmt_read_write_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if ((cfg_mgmt_read || cfg_mgmt_write) && !cfg_mgmt_read_write_done) begin
                        lat_addr  <= cfg_mgmt_addr;
                        lat_func  <= cfg_mgmt_function_number;
                        lat_data  <= cfg_mgmt_write_data;
                        lat_be    <= cfg_mgmt_byte_enable;
                        lat_write <= cfg_mgmt_write;
                        cnt       <= CNT_INIT;
                        state     <= (LATENCY == 1) ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt == 3'd1) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_DONE: begin
                    cfg_mgmt_read_write_done <= 1'b1;
                    cfg_mgmt_read_data       <= lat_write ? '0 : rd_val;
                    state                    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_dw    <= '0;
            cache_dw  <= '0;
            intr_dw   <= '0;
            msictl_dw <= '0;
            msi_alo   <= '0;
            msi_ahi   <= '0;
            msi_dat   <= '0;
        end else if (wr_en) begin
            case (lat_addr)
                DW_CMD:      cmd_dw    <= apply_be(cmd_dw, lat_data, lat_be, {16'h0, CMD_RW_MASK});
                DW_CACHE:    cache_dw  <= apply_be(cache_dw, lat_data, lat_be, 32'h0000_00FF);
                DW_INTR:     intr_dw   <= apply_be(intr_dw, lat_data, lat_be, 32'h0000_00FF);
                DW_MSI_CTL:  msictl_dw <= apply_be(msictl_dw, lat_data, lat_be, 32'h0001_0000);
                DW_MSI_ALO:  msi_alo   <= apply_be(msi_alo, lat_data, lat_be, 32'hFFFF_FFFC);
                DW_MSI_AHI:  msi_ahi   <= apply_be(msi_ahi, lat_data, lat_be, 32'hFFFF_FFFF);
                DW_MSI_DATA: msi_dat   <= apply_be(msi_dat, lat_data, lat_be, 32'h0000_FFFF);
                default: ;
            endcase
        end
    end

    pcie_cfg_bar64_reg #(.APERTURE(BAR0_APERTURE)) u_bar0 (
        .clk         (clk),
        .rst         (rst),
        .wr_lo       (wr_en && (lat_addr == DW_BAR0_LO)),
        .wr_hi       (wr_en && (lat_addr == DW_BAR0_HI)),
        .write_data  (lat_data),
        .byte_enable (lat_be),
        .read_lo     (bar0_lo),
        .read_hi     (bar0_hi),
        .base        (bar0_val)
    );

    pcie_cfg_bar64_reg #(.APERTURE(BAR2_APERTURE)) u_bar2 (
        .clk         (clk),
        .rst         (rst),
        .wr_lo       (wr_en && (lat_addr == DW_BAR2_LO)),
        .wr_hi       (wr_en && (lat_addr == DW_BAR2_HI)),
        .write_data  (lat_data),
        .byte_enable (lat_be),
        .read_lo     (bar2_lo),
        .read_hi     (bar2_hi),
        .base        (bar2_val)
    );

    always_comb begin
        rd_val = '0;
        if (hit) begin
            case (lat_addr)
                DW_ID:       rd_val = {DEVICE_ID, VENDOR_ID};
                DW_CMD:      rd_val = cmd_dw | {STATUS_VAL, 16'h0};
                DW_CLASS:    rd_val = CLASS_REV;
                DW_CACHE:    rd_val = cache_dw;
                DW_BAR0_LO:  rd_val = bar0_lo;
                DW_BAR0_HI:  rd_val = bar0_hi;
                DW_BAR2_LO:  rd_val = bar2_lo;
                DW_BAR2_HI:  rd_val = bar2_hi;
                DW_CAP_PTR:  rd_val = {24'h0, MSI_CAP_OFF};
                DW_INTR:     rd_val = intr_dw | {16'h0, INTR_PIN, 8'h0};
                DW_MSI_CTL:  rd_val = msictl_dw | {8'h0, MSI_CTL_64, 8'h00, MSI_CAP_ID};
                DW_MSI_ALO:  rd_val = msi_alo;
                DW_MSI_AHI:  rd_val = msi_ahi;
                DW_MSI_DATA: rd_val = msi_dat;
                default:     rd_val = '0;
            endcase
        end
    end

    // Exports follow the registers one cycle later, i.e. the cycle after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_space_enable  <= 1'b0;
            bus_master_enable <= 1'b0;
            bar0_base         <= '0;
            bar2_base         <= '0;
            msi_enable        <= 1'b0;
            msi_addr          <= '0;
            msi_data          <= '0;
        end else begin
            mem_space_enable  <= cmd_dw[1];
            bus_master_enable <= cmd_dw[2];
            bar0_base         <= bar0_val;
            bar2_base         <= bar2_val;
            msi_enable        <= msictl_dw[16];
            msi_addr          <= {msi_ahi, msi_alo};
            msi_data          <= msi_dat[15:0];
        end
    end

endmodule

// File: tb/tb_pcie_cfg_mgmt_target.sv
// Directed bench for pcie_cfg_mgmt_target with hand-computed expected values.
module tb_pcie_cfg_mgmt_target;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  cfg_mgmt_addr;
    logic [7:0]  cfg_mgmt_function_number;
    logic        cfg_mgmt_write;
    logic [31:0] cfg_mgmt_write_data;
    logic [3:0]  cfg_mgmt_byte_enable;
    logic        cfg_mgmt_read;
    logic [31:0] cfg_mgmt_read_data;
    logic        cfg_mgmt_read_write_done;
    logic        mem_space_enable;
    logic        bus_master_enable;
    logic [63:0] bar0_base;
    logic [63:0] bar2_base;
    logic        msi_enable;
    logic [63:0] msi_addr;
    logic [15:0] msi_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pcie_cfg_mgmt_target #(
        .VENDOR_ID     (16'h1234),
        .DEVICE_ID     (16'h0001),
        .CLASS_REV     (32'h02000000),
        .BAR0_APERTURE (24),
        .BAR2_APERTURE (24),
        .LATENCY       (2)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .cfg_mgmt_addr            (cfg_mgmt_addr),
        .cfg_mgmt_function_number (cfg_mgmt_function_number),
        .cfg_mgmt_write           (cfg_mgmt_write),
        .cfg_mgmt_write_data      (cfg_mgmt_write_data),
        .cfg_mgmt_byte_enable     (cfg_mgmt_byte_enable),
        .cfg_mgmt_read            (cfg_mgmt_read),
        .cfg_mgmt_read_data       (cfg_mgmt_read_data),
        .cfg_mgmt_read_write_done (cfg_mgmt_read_write_done),
        .mem_space_enable         (mem_space_enable),
        .bus_master_enable        (bus_master_enable),
        .bar0_base                (bar0_base),
        .bar2_base                (bar2_base),
        .msi_enable               (msi_enable),
        .msi_addr                 (msi_addr),
        .msi_data                 (msi_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Request is raised just before the sampling edge and held through done;
    // lat counts edges from the first request edge to the edge raising done.
    task automatic xact(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [7:0] fn, input logic w, input logic r,
                        output int lat, output logic [31:0] rdata, output logic ms_at_done);
        @(posedge clk); #1;
        cfg_mgmt_addr            = a;
        cfg_mgmt_write_data      = d;
        cfg_mgmt_byte_enable     = be;
        cfg_mgmt_function_number = fn;
        cfg_mgmt_write           = w;
        cfg_mgmt_read            = r;
        @(posedge clk);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (cfg_mgmt_read_write_done) break;
        end
        check("done_seen", {63'h0, cfg_mgmt_read_write_done}, 64'd1);
        rdata      = cfg_mgmt_read_data;
        ms_at_done = mem_space_enable;
        @(posedge clk); #1;
        check("done_one_shot", {63'h0, cfg_mgmt_read_write_done}, 64'd0);
        cfg_mgmt_write = 1'b0;
        cfg_mgmt_read  = 1'b0;
    endtask

    initial begin
        int          lat;
        int          ndone;
        int          first;
        logic [31:0] rd;
        logic        ms;

        rst = 1'b1;
        cfg_mgmt_addr = '0;
        cfg_mgmt_function_number = '0;
        cfg_mgmt_write = 1'b0;
        cfg_mgmt_write_data = '0;
        cfg_mgmt_byte_enable = '0;
        cfg_mgmt_read = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_read_data", {32'h0, cfg_mgmt_read_data}, 64'd0);
        check("rst_done", {63'h0, cfg_mgmt_read_write_done}, 64'd0);
        check("rst_bar0", bar0_base, 64'd0);
        check("rst_msi_addr", msi_addr, 64'd0);
        check("rst_cmd_en", {62'h0, mem_space_enable, bus_master_enable}, 64'd0);

        // Read DW0 with request held over four sampling edges: exactly one done.
        @(posedge clk); #1;
        cfg_mgmt_addr = 10'd0;
        cfg_mgmt_read = 1'b1;
        ndone = 0;
        first = -1;
        rd    = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (cfg_mgmt_read_write_done) begin
                ndone++;
                if (first < 0) begin
                    first = i;
                    rd    = cfg_mgmt_read_data;
                end
            end
            if (i == 3) cfg_mgmt_read = 1'b0;
        end
        check("dw0_latency", 64'(first), 64'd2);
        check("dw0_data", {32'h0, rd}, 64'h0001_1234);
        check("dw0_single_done", 64'(ndone), 64'd1);

        xact(10'd0, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("task_latency", 64'(lat), 64'd2);

        // Other function and out-of-range addresses are inert.
        xact(10'd1, 32'h6, 4'hF, 8'd1, 1'b1, 1'b0, lat, rd, ms);
        check("fn1_write_latency", 64'(lat), 64'd2);
        xact(10'd1, 32'h0, 4'h0, 8'd1, 1'b0, 1'b1, lat, rd, ms);
        check("fn1_read", {32'h0, rd}, 64'd0);
        xact(10'd1, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("fn0_cmd_untouched", {32'h0, rd}, 64'h0010_0000);
        check("fn1_no_enable", {63'h0, mem_space_enable}, 64'd0);
        xact(10'd25, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("dw25_read", {32'h0, rd}, 64'd0);

        xact(10'd2, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("class_rev", {32'h0, rd}, 64'h0200_0000);
        xact(10'd13, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("cap_ptr", {32'h0, rd}, 64'h40);

        // BAR0 sizing.
        xact(10'd4, 32'hFFFF_FFFF, 4'hF, 8'd0, 1'b1, 1'b0, lat, rd, ms);
        xact(10'd4, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("bar0_lo_size", {32'h0, rd}, 64'hFF00_000C);
        xact(10'd5, 32'hFFFF_FFFF, 4'hF, 8'd0, 1'b1, 1'b0, lat, rd, ms);
        xact(10'd5, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("bar0_hi_size", {32'h0, rd}, 64'hFFFF_FFFF);
        check("bar0_base", bar0_base, 64'hFFFF_FFFF_FF00_0000);
        xact(10'd6, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("bar2_lo_reset", {32'h0, rd}, 64'h0000_000C);
        check("bar2_base", bar2_base, 64'd0);

        // Command register masking and export timing.
        xact(10'd1, 32'hFFFF_FFFF, 4'hF, 8'd0, 1'b1, 1'b0, lat, rd, ms);
        check("mse_at_done", {63'h0, ms}, 64'd0);
        check("mse_after_done", {63'h0, mem_space_enable}, 64'd1);
        check("bme_after_done", {63'h0, bus_master_enable}, 64'd1);
        xact(10'd1, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("cmd_masked", {32'h0, rd}, 64'h0010_0546);

        xact(10'd3, 32'h1234_5678, 4'h1, 8'd0, 1'b1, 1'b0, lat, rd, ms);
        xact(10'd3, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("cache_line", {32'h0, rd}, 64'h78);

        // MSI capability.
        xact(10'd17, 32'h1234_5677, 4'h3, 8'd0, 1'b1, 1'b0, lat, rd, ms);
        xact(10'd17, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("msi_addr_lo", {32'h0, rd}, 64'h0000_5674);
        xact(10'd16, 32'h0001_0000, 4'hF, 8'd0, 1'b1, 1'b0, lat, rd, ms);
        check("msi_enable", {63'h0, msi_enable}, 64'd1);
        xact(10'd16, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("msi_ctl", {32'h0, rd}, 64'h0081_0005);
        check("msi_addr_out", msi_addr, 64'h0000_0000_0000_5674);

        // Read and write together behave as a write returning zero.
        xact(10'd19, 32'h1234_ABCD, 4'hF, 8'd0, 1'b1, 1'b1, lat, rd, ms);
        check("rw_both_data", {32'h0, rd}, 64'd0);
        xact(10'd19, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("msi_data_rd", {32'h0, rd}, 64'h0000_ABCD);
        check("msi_data_out", {48'h0, msi_data}, 64'hABCD);

        xact(10'd15, 32'h0000_00AB, 4'hF, 8'd0, 1'b1, 1'b0, lat, rd, ms);
        xact(10'd15, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("intr_line", {32'h0, rd}, 64'h0000_01AB);

        // Reset one cycle into a write of DW15: no done pulse.
        @(posedge clk); #1;
        cfg_mgmt_addr        = 10'd15;
        cfg_mgmt_write_data  = 32'h0000_0055;
        cfg_mgmt_byte_enable = 4'hF;
        cfg_mgmt_write       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cfg_mgmt_write = 1'b0;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (cfg_mgmt_read_write_done) ndone++;
        end
        check("rst_mid_no_done", 64'(ndone), 64'd0);
        xact(10'd15, 32'h0, 4'h0, 8'd0, 1'b0, 1'b1, lat, rd, ms);
        check("rst_mid_dw15", {32'h0, rd}, 64'h0000_0100);
        check("rst_mid_mse", {63'h0, mem_space_enable}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
